// File: rtl/rib_store_buffer_if.sv
// Core-side and bus-side signal bundle for the posted-write store buffer.
//   c_addr_i/c_data_i/c_req_i/c_we_i : core access request (from core)
//   c_data_o/c_hold_o                : load data and stall back to core
//   m_addr_o/m_data_o/m_req_o/m_we_o : RIB master port 0 request (to bus)
//   m_data_i/m_gnt_i                 : bus read data and completion
// slave  : the store buffer's view
// master : the environment's view (core + bus)
interface rib_store_buffer_if;
  logic [31:0] c_addr_i;
  logic [31:0] c_data_i;
  logic        c_req_i;
  logic        c_we_i;
  logic [31:0] c_data_o;
  logic        c_hold_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_data_o;
  logic [31:0] m_data_i;
  logic        m_req_o;
  logic        m_we_o;
  logic        m_gnt_i;

  modport slave (
    input  c_addr_i, c_data_i, c_req_i, c_we_i, m_data_i, m_gnt_i,
    output c_data_o, c_hold_o, m_addr_o, m_data_o, m_req_o, m_we_o
  );

  modport master (
    output c_addr_i, c_data_i, c_req_i, c_we_i, m_data_i, m_gnt_i,
    input  c_data_o, c_hold_o, m_addr_o, m_data_o, m_req_o, m_we_o
  );
endinterface

// File: rtl/rib_store_buffer.sv
// Posted-write buffer between the core data port and RIB master port 0.
// Stores to BUF_REGION retire into a FIFO and drain in the background; loads to
// BUF_REGION are forwarded from the youngest matching pending entry; MMIO
// accesses wait until the FIFO is empty.
// Ports:
//   clk     : core clock
//   rst     : asynchronous active-low reset
//   bus     : core + bus signals (rib_store_buffer_if.slave)
//   empty_o : no pending stores
module rib_store_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [3:0]  BUF_REGION = 4'h1
) (
  input  logic                     clk,
  input  logic                     rst,
  rib_store_buffer_if.slave        bus,
  output logic                     empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic        in_region, st_buf, ld_buf, mmio;
  logic        full, enq, pop, bus_busy;
  logic        hit;
  logic [31:0] fwd_data;
  logic [PtrW-1:0] idx;

  assign in_region = (bus.c_addr_i[31:28] == BUF_REGION);
  assign st_buf    = bus.c_req_i &  bus.c_we_i & in_region;
  assign ld_buf    = bus.c_req_i & ~bus.c_we_i & in_region;
  assign mmio      = bus.c_req_i & ~in_region;
  assign full      = (count_q == CntW'(DEPTH));
  assign empty_o   = (count_q == '0);

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PtrW'(k);
      if ((CntW'(k) < count_q) && (addr_q[idx] == bus.c_addr_i)) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  always_comb begin
    bus.c_data_o = '0;
    bus.c_hold_o = 1'b0;
    bus.m_req_o  = 1'b0;
    bus.m_we_o   = 1'b0;
    bus.m_addr_o = '0;
    bus.m_data_o = '0;
    enq          = 1'b0;
    pop          = 1'b0;
    bus_busy     = 1'b0;

    if (st_buf) begin
      // A full buffer stalls even if the head pops this cycle.
      if (!full) enq = 1'b1;
      else       bus.c_hold_o = 1'b1;
    end else if (ld_buf) begin
      if (hit) begin
        bus.c_data_o = fwd_data;
      end else begin
        bus_busy     = 1'b1;
        bus.m_req_o  = 1'b1;
        bus.m_addr_o = bus.c_addr_i;
        bus.c_data_o = bus.m_data_i;
        bus.c_hold_o = ~bus.m_gnt_i;
      end
    end else if (mmio) begin
      if (!empty_o) begin
        bus.c_hold_o = 1'b1;
      end else begin
        bus_busy     = 1'b1;
        bus.m_req_o  = 1'b1;
        bus.m_we_o   = bus.c_we_i;
        bus.m_addr_o = bus.c_addr_i;
        bus.m_data_o = bus.c_data_i;
        bus.c_data_o = bus.m_data_i;
        bus.c_hold_o = ~bus.m_gnt_i;
      end
    end

    if (!bus_busy && !empty_o) begin
      bus.m_req_o  = 1'b1;
      bus.m_we_o   = 1'b1;
      bus.m_addr_o = addr_q[rd_ptr_q];
      bus.m_data_o = data_q[rd_ptr_q];
      pop          = bus.m_gnt_i;
    end
  end

  always_comb begin
    count_d = count_q;
    if (enq && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !enq) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Entry contents need no reset; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= bus.c_addr_i;
      data_q[wr_ptr_q] <= bus.c_data_i;
    end
  end

endmodule

// File: tb/tb_rib_store_buffer.sv
module tb_rib_store_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic empty;

  rib_store_buffer_if sb_if ();

  rib_store_buffer #(.DEPTH(4), .BUF_REGION(4'h1)) dut (
    .clk     (clk),
    .rst     (rst_n),
    .bus     (sb_if),
    .empty_o (empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; } entry_t;
  entry_t q[$];
  int wr_log = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic gnt, input logic [31:0] rdata);
    sb_if.c_req_i  = req;
    sb_if.c_we_i   = we;
    sb_if.c_addr_i = addr;
    sb_if.c_data_i = data;
    sb_if.m_gnt_i  = gnt;
    sb_if.m_data_i = rdata;
  endtask

  // Reference: the pending stores are a queue; outputs follow the per-cycle rules.
  task automatic step(input string tag);
    logic e_hold, e_req, e_we, cd_valid, enq, pop, busy, hit, region;
    logic [31:0] e_addr, e_data, e_cdata;
    int cnt;
    @(negedge clk);
    cnt = q.size();
    region = (sb_if.c_addr_i[31:28] == 4'h1);
    e_hold = 0; e_req = 0; e_we = 0; e_addr = 0; e_data = 0;
    cd_valid = 0; e_cdata = 0; enq = 0; pop = 0; busy = 0; hit = 0;
    if (sb_if.c_req_i && sb_if.c_we_i && region) begin
      if (cnt < 4) enq = 1; else e_hold = 1;
    end else if (sb_if.c_req_i && !sb_if.c_we_i && region) begin
      for (int i = cnt - 1; i >= 0 && !hit; i--)
        if (q[i].addr == sb_if.c_addr_i) begin hit = 1; e_cdata = q[i].data; end
      cd_valid = 1;
      if (!hit) begin
        busy = 1; e_req = 1; e_addr = sb_if.c_addr_i;
        e_cdata = sb_if.m_data_i; e_hold = !sb_if.m_gnt_i;
      end
    end else if (sb_if.c_req_i) begin
      if (cnt != 0) e_hold = 1;
      else begin
        busy = 1; e_req = 1; e_we = sb_if.c_we_i; e_addr = sb_if.c_addr_i;
        e_data = sb_if.c_data_i; e_hold = !sb_if.m_gnt_i;
        cd_valid = !sb_if.c_we_i; e_cdata = sb_if.m_data_i;
      end
    end else if (cnt == 0) begin
      cd_valid = 1; e_cdata = 0;
    end
    if (!busy && cnt > 0) begin
      e_req = 1; e_we = 1; e_addr = q[0].addr; e_data = q[0].data; pop = sb_if.m_gnt_i;
    end

    check_eq({tag, " hold"}, 32'(sb_if.c_hold_o), 32'(e_hold));
    check_eq({tag, " m_req"}, 32'(sb_if.m_req_o), 32'(e_req));
    check_eq({tag, " empty"}, 32'(empty), 32'(cnt == 0));
    if (e_req) begin
      check_eq({tag, " m_we"}, 32'(sb_if.m_we_o), 32'(e_we));
      check_eq({tag, " m_addr"}, sb_if.m_addr_o, e_addr);
      if (e_we) check_eq({tag, " m_data"}, sb_if.m_data_o, e_data);
    end
    if (cd_valid) check_eq({tag, " c_data"}, sb_if.c_data_o, e_cdata);

    @(posedge clk);
    if (pop) begin void'(q.pop_front()); wr_log++; end
    if (enq) q.push_back('{addr: sb_if.c_addr_i, data: sb_if.c_data_i});
    #1;
  endtask

  task automatic idle(input logic gnt);
    drive(1'b0, 1'b0, 32'h0, 32'h0, gnt, 32'h0);
  endtask

  int writes_before;

  initial begin
    idle(1'b0);
    #12;
    check_eq("reset hold", 32'(sb_if.c_hold_o), 32'd0);
    check_eq("reset m_req", 32'(sb_if.m_req_o), 32'd0);
    check_eq("reset m_we", 32'(sb_if.m_we_o), 32'd0);
    check_eq("reset empty", 32'(empty), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: buffered store, granted drain next cycle
    drive(1, 1, 32'h1000_0000, 32'hDEAD_BEEF, 1, 0); step("t1 store");
    idle(1); step("t1 drain");
    idle(1); step("t1 done");

    // T2: forward from pending store, no bus read
    drive(1, 1, 32'h1000_0004, 32'h11, 0, 0); step("t2 store");
    drive(1, 0, 32'h1000_0004, 0, 0, 32'h5555_5555); step("t2 fwd");
    idle(1); step("t2 drain");

    // T3: overflow stall then accept after one grant
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'h1000_0100 + 32'(i * 4), 32'h100 + 32'(i), 0, 0); step("t3 fill");
    end
    drive(1, 1, 32'h1000_0110, 32'h104, 1, 0); step("t3 pop");
    drive(1, 1, 32'h1000_0110, 32'h104, 0, 0); step("t3 accept");
    for (int i = 0; i < 6; i++) begin idle(1); step("t3 drain"); end

    // T4: MMIO store held behind two pending RAM stores
    drive(1, 1, 32'h1000_0020, 32'h20, 0, 0); step("t4 st0");
    drive(1, 1, 32'h1000_0024, 32'h24, 0, 0); step("t4 st1");
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h4000_0000, 32'hCAFE, i[0], 0); step("t4 mmio held");
    end
    drive(1, 1, 32'h4000_0000, 32'hCAFE, 1, 0); step("t4 mmio go");

    // T5: youngest of two same-address stores forwarded, both drain in order
    drive(1, 1, 32'h1000_0008, 32'hA, 0, 0); step("t5 st a");
    drive(1, 1, 32'h1000_0008, 32'hB, 0, 0); step("t5 st b");
    drive(1, 0, 32'h1000_0008, 0, 1, 32'h77); step("t5 fwd");
    for (int i = 0; i < 3; i++) begin idle(1); step("t5 drain"); end

    // T6: async reset discards pending entries
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h1000_0040 + 32'(i * 4), 32'h40 + 32'(i), 0, 0); step("t6 fill");
    end
    idle(0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6 async m_req", 32'(sb_if.m_req_o), 32'd0);
    check_eq("t6 async empty", 32'(empty), 32'd1);
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    writes_before = wr_log;
    for (int i = 0; i < 4; i++) begin idle(1); step("t6 after"); end
    check_eq("t6 no writes", 32'(wr_log), 32'(writes_before));

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) < 8) a = 32'h1000_0000 | (32'($urandom_range(0, 3)) << 2);
      else a = 32'h4000_0000 | (32'($urandom_range(0, 3)) << 2);
      drive($urandom_range(0, 9) < 8, 1'($urandom), a, $urandom,
            $urandom_range(0, 2) != 0, $urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
